// File: rtl/fpmult_pkg.sv
// Shared binary32 constants, packed-float layout and exponent decode for the FP multiplier.
package fpmult_pkg;

  localparam int unsigned BIAS      = 127;
  localparam int unsigned EXP_MAX   = 255;
  localparam logic [31:0] QNAN      = 32'h7FC00000;
  localparam int unsigned MANT_W    = 23;
  localparam int unsigned PROD_W    = 48;
  localparam int unsigned EXP_INT_W = 10;

  typedef struct packed {
    logic              sign;
    logic [7:0]        exp;
    logic [MANT_W-1:0] frac;
  } float_t;

  // Ep >= 384 is a wrapped negative exponent; its signed value is Ep-512.
  function automatic logic signed [EXP_INT_W-1:0] decode_exp(input logic [8:0] ep);
    return {ep[8] & ep[7], ep};
  endfunction

endpackage

// File: rtl/fpmult_round_rne.sv
// Round-to-nearest-even increment of a 23-bit fraction from its guard and sticky bits.
module fpmult_round_rne
  import fpmult_pkg::*;
(
  input  logic [MANT_W-1:0] i_frac,
  input  logic              i_g,
  input  logic              i_s,
  output logic [MANT_W-1:0] o_frac,
  output logic              o_carry
);

  logic w_up;

  assign w_up = i_g & (i_s | i_frac[0]);
  assign {o_carry, o_frac} = {1'b0, i_frac} + {{MANT_W{1'b0}}, w_up};

endmodule

// File: rtl/fpmult_norm_round.sv
// Two-stage normalize / round-pack of the binary32 multiplier product behind valid/ready.
module fpmult_norm_round
  import fpmult_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [8:0]        Ep,
  input  logic              Sp,
  input  logic [PROD_W-1:0] Mp,
  input  logic              i_nan,
  input  logic              i_inf,
  input  logic              i_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       P,
  output logic              overflow,
  output logic              underflow,
  output logic              inexact
);

  localparam logic signed [EXP_INT_W-1:0] EMax = EXP_INT_W'(EXP_MAX);

  // Stage 1 state
  logic                        r_s1_valid;
  logic signed [EXP_INT_W-1:0] r_s1_e;
  logic [MANT_W-1:0]           r_s1_frac;
  logic                        r_s1_g, r_s1_s, r_s1_sign;
  logic                        r_s1_nan, r_s1_inf, r_s1_zero;

  // Stage 2 (output) state
  logic   r_out_valid;
  float_t r_p;
  logic   r_ov, r_un, r_ix;

  logic                        w_s1_adv, w_s2_adv;
  logic signed [EXP_INT_W-1:0] w_e_dec, w_e_n;
  logic [MANT_W-1:0]           w_frac_n;
  logic                        w_g_n, w_s_n;

  logic [MANT_W-1:0]           w_frac_r;
  logic                        w_carry;
  logic signed [EXP_INT_W-1:0] w_e_r;
  float_t                      w_p_d;
  logic                        w_ov_d, w_un_d, w_ix_d;

  assign w_s2_adv = !r_out_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  assign w_e_dec = decode_exp(Ep);

  always_comb begin
    if (Mp[47]) begin
      w_frac_n = Mp[46:24];
      w_g_n    = Mp[23];
      w_s_n    = |Mp[22:0];
      w_e_n    = w_e_dec + 10'sd1;
    end else begin
      w_frac_n = Mp[45:23];
      w_g_n    = Mp[22];
      w_s_n    = |Mp[21:0];
      w_e_n    = w_e_dec;
    end
  end

  fpmult_round_rne u_round (
    .i_frac  (r_s1_frac),
    .i_g     (r_s1_g),
    .i_s     (r_s1_s),
    .o_frac  (w_frac_r),
    .o_carry (w_carry)
  );

  assign w_e_r = r_s1_e + $signed({{(EXP_INT_W-1){1'b0}}, w_carry});

  always_comb begin
    w_p_d  = '0;
    w_ov_d = 1'b0;
    w_un_d = 1'b0;
    w_ix_d = 1'b0;
    if (r_s1_nan) begin
      w_p_d = QNAN;
    end else if (r_s1_inf) begin
      w_p_d.sign = r_s1_sign;
      w_p_d.exp  = 8'hFF;
    end else if (r_s1_zero) begin
      w_p_d.sign = r_s1_sign;
    end else if (w_e_r >= EMax) begin
      w_p_d.sign = r_s1_sign;
      w_p_d.exp  = 8'hFF;
      w_ov_d     = 1'b1;
    end else if (w_e_r <= 10'sd0) begin
      w_p_d.sign = r_s1_sign;
      w_un_d     = 1'b1;
    end else begin
      w_p_d.sign = r_s1_sign;
      w_p_d.exp  = w_e_r[7:0];
      w_p_d.frac = w_frac_r;
      w_ix_d     = r_s1_g | r_s1_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_e      <= '0;
      r_s1_frac   <= '0;
      r_s1_g      <= 1'b0;
      r_s1_s      <= 1'b0;
      r_s1_sign   <= 1'b0;
      r_s1_nan    <= 1'b0;
      r_s1_inf    <= 1'b0;
      r_s1_zero   <= 1'b0;
      r_out_valid <= 1'b0;
      r_p         <= '0;
      r_ov        <= 1'b0;
      r_un        <= 1'b0;
      r_ix        <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_e    <= w_e_n;
          r_s1_frac <= w_frac_n;
          r_s1_g    <= w_g_n;
          r_s1_s    <= w_s_n;
          r_s1_sign <= Sp;
          r_s1_nan  <= i_nan;
          r_s1_inf  <= i_inf;
          r_s1_zero <= i_zero;
        end
      end
      if (w_s2_adv) begin
        r_out_valid <= r_s1_valid;
        // Result registers only change on a real beat so P stays put between beats.
        if (r_s1_valid) begin
          r_p  <= w_p_d;
          r_ov <= w_ov_d;
          r_un <= w_un_d;
          r_ix <= w_ix_d;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign P         = r_p;
  assign overflow  = r_ov;
  assign underflow = r_un;
  assign inexact   = r_ix;

endmodule

// File: tb/tb_fpmult_norm_round.sv
// Bench for fpmult_norm_round: directed corner cases, stall/reset handling, random products.
module tb_fpmult_norm_round;
  import fpmult_pkg::*;

  typedef struct packed {
    logic [31:0] p;
    logic        ov;
    logic        un;
    logic        ix;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [8:0]  Ep;
  logic        Sp;
  logic [47:0] Mp;
  logic        i_nan, i_inf, i_zero;
  logic        out_valid, out_ready;
  logic [31:0] P;
  logic        overflow, underflow, inexact;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_rx    = 0;
  int   n_exp   = 0;
  bit   rnd_ready = 1'b0;
  res_t q[$];

  always #5 clk = ~clk;

  fpmult_norm_round dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Ep        (Ep),
    .Sp        (Sp),
    .Mp        (Mp),
    .i_nan     (i_nan),
    .i_inf     (i_inf),
    .i_zero    (i_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .P         (P),
    .overflow  (overflow),
    .underflow (underflow),
    .inexact   (inexact)
  );

  // Reference: exact integer rounding of the product, then exponent range classification.
  function automatic res_t model(input logic [8:0] ep, input logic sp, input logic [47:0] mp,
                                 input logic nan, input logic inf, input logic zero);
    res_t        r;
    int          e, sh;
    logic [63:0] mant, rem, half;
    r = '0;
    if (nan) begin
      r.p = QNAN;
    end else if (inf) begin
      r.p = {sp, 8'hFF, 23'h0};
    end else if (zero) begin
      r.p = {sp, 31'h0};
    end else begin
      e  = (ep < 384) ? int'(ep) : int'(ep) - 512;
      sh = mp[47] ? 24 : 23;
      if (mp[47]) e++;
      mant = 64'(mp) >> sh;
      rem  = 64'(mp) & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && mant[0])) mant++;
      if (mant == (64'd1 << 24)) begin
        mant = mant >> 1;
        e++;
      end
      if (e >= int'(EXP_MAX)) begin
        r.p  = {sp, 8'hFF, 23'h0};
        r.ov = 1'b1;
      end else if (e <= 0) begin
        r.p  = {sp, 31'h0};
        r.un = 1'b1;
      end else begin
        r.p  = {sp, 8'(e), mant[22:0]};
        r.ix = (rem != 64'd0);
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Output beats transfer at the next rising edge when valid & ready are seen here.
  always @(negedge clk) begin
    res_t e;
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_beat", 64'(q.size()), 64'd1);
      end else begin
        e = q.pop_front();
        chk($sformatf("result_%0d", n_rx), {P, overflow, underflow, inexact},
            {e.p, e.ov, e.un, e.ix});
        n_rx++;
      end
    end
  end

  task automatic send(input logic [8:0] ep, input logic sp, input logic [47:0] mp,
                      input logic nan, input logic inf, input logic zero);
    int cyc = 0;
    bit done = 1'b0;
    Ep = ep; Sp = sp; Mp = mp; i_nan = nan; i_inf = inf; i_zero = zero;
    in_valid = 1'b1;
    while (!done) begin
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_ready) begin
        q.push_back(model(ep, sp, mp, nan, inf, zero));
        n_exp++;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (!done && cyc > 200) begin
        chk("send_timeout", 64'(cyc), 64'd0);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int cyc = 0;
    out_ready = 1'b1;
    while (q.size() != 0 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  initial begin
    logic [23:0] ma, mb;
    logic [8:0]  ep;
    in_valid = 1'b0; out_ready = 1'b1; rst_n = 1'b0;
    Ep = '0; Sp = 1'b0; Mp = '0; i_nan = 1'b0; i_inf = 1'b0; i_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_P", 64'(P), 64'd0);
    chk("rst_flags", 64'({overflow, underflow, inexact}), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: accepted at an edge, visible right after the following edge, once only.
    send(9'(BIAS), 1'b0, 48'h400000000000, 1'b0, 1'b0, 1'b0);
    chk("lat_after_accept", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_P", 64'(P), 64'h3F800000);
    @(posedge clk);
    #1;
    chk("lat_no_dup", 64'(out_valid), 64'd0);

    // Directed corner cases, back to back.
    send(9'd127, 1'b0, 48'h900000000000, 1'b0, 1'b0, 1'b0);
    send(9'd127, 1'b0, 48'h400000400000, 1'b0, 1'b0, 1'b0);
    send(9'd127, 1'b0, 48'h400000C00000, 1'b0, 1'b0, 1'b0);
    send(9'd127, 1'b0, 48'h7FFFFFC00000, 1'b0, 1'b0, 1'b0);
    send(9'd254, 1'b1, 48'h800000000000, 1'b0, 1'b0, 1'b0);
    send(9'd385, 1'b0, 48'h400000000000, 1'b0, 1'b0, 1'b0);
    send(9'd384, 1'b1, 48'hC00000000000, 1'b0, 1'b0, 1'b0);
    send(9'd1,   1'b0, 48'h400000000000, 1'b0, 1'b0, 1'b0);
    send(9'd0,   1'b0, 48'h400000000000, 1'b0, 1'b0, 1'b0);
    send(9'd253, 1'b0, 48'h7FFFFFC00000, 1'b0, 1'b0, 1'b0);
    send(9'd127, 1'b0, 48'h000000000000, 1'b1, 1'b0, 1'b1);
    send(9'd300, 1'b1, 48'h123456789ABC, 1'b0, 1'b1, 1'b0);
    send(9'd2,   1'b1, 48'h000000000001, 1'b0, 1'b0, 1'b1);
    drain();

    // Stall: two beats fill both stages, then the front end must back off.
    out_ready = 1'b0;
    send(9'd130, 1'b0, 48'h500000000000, 1'b0, 1'b0, 1'b0);
    send(9'd131, 1'b1, 48'hA00000000001, 1'b0, 1'b0, 1'b0);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    chk("stall_out_valid", 64'(out_valid), 64'd1);
    chk("stall_P0", 64'(P), 64'(q[0].p));
    repeat (3) @(posedge clk);
    #1;
    chk("stall_in_ready_held", 64'(in_ready), 64'd0);
    chk("stall_P_held", 64'(P), 64'(q[0].p));
    out_ready = 1'b1;
    send(9'd132, 1'b0, 48'h600000000000, 1'b0, 1'b0, 1'b0);
    send(9'd133, 1'b1, 48'h700000000000, 1'b0, 1'b0, 1'b0);
    send(9'd134, 1'b0, 48'hF00000000000, 1'b0, 1'b0, 1'b0);
    drain();

    // Reset mid-stream discards everything in flight.
    out_ready = 1'b0;
    send(9'd140, 1'b0, 48'h400000000000, 1'b0, 1'b0, 1'b0);
    send(9'd141, 1'b0, 48'h400000000000, 1'b0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
    n_exp -= q.size();
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_flushed", 64'(out_valid), 64'd0);
    send(9'd150, 1'b1, 48'h480000000000, 1'b0, 1'b0, 1'b0);
    drain();

    // Random normalized products with random downstream back-pressure.
    rnd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ma = 24'h800000 | 24'($urandom_range(0, 24'h7FFFFF));
      mb = 24'h800000 | 24'($urandom_range(0, 24'h7FFFFF));
      ep = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511))
                                       : 9'($urandom_range(100, 160));
      send(ep, 1'($urandom), 48'(ma) * 48'(mb), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
    end
    rnd_ready = 1'b0;
    drain();
    chk("rx_count", 64'(n_rx), 64'(n_exp));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
